single_port_ram_arbiter: RTL



---
 rtl/single_port_ram_arbiter_pkg.sv | 12 +
 rtl/single_port_ram_arbiter_rr_pick.sv | 36 +++
 rtl/single_port_ram_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/single_port_ram_arbiter_pkg.sv
// Shared constants for the single-port RAM arbiter: FSM state codes and pointer wrap helper.
// The lock FSM states are only reachable when SPRA_LOCK_EN is defined.
package single_port_ram_arbiter_pkg;

   localparam logic ST_ARB    = 1'b0;
   localparam logic ST_LOCKED = 1'b1;

   function automatic int wrap_inc(input int k, input int n);
      return (k + 1 >= n) ? 0 : k + 1;
   endfunction

endpackage

// File: rtl/single_port_ram_arbiter_rr_pick.sv
// Round-robin picker: first set request scanning upward from ptr, wrapping to slot 0.
// Pure combinational; returns a one-hot grant, its encoded index and an any-winner flag.
module rr_pick
   import single_port_ram_arbiter_pkg::*;
#(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [PW-1:0] o_idx,
   output logic          o_any
);

   localparam int SW = PW + 1;

   logic [SW-1:0] w_slot;

   always_comb begin
      o_gnt  = '0;
      o_idx  = '0;
      o_any  = 1'b0;
      w_slot = '0;
      for (int i = 0; i < N; i++) begin
         w_slot = {1'b0, i_ptr} + SW'(i);
         if (w_slot >= SW'(N)) w_slot = w_slot - SW'(N);
         if (!o_any && i_req[w_slot[PW-1:0]]) begin
            o_any                 = 1'b1;
            o_idx                 = w_slot[PW-1:0];
            o_gnt[w_slot[PW-1:0]] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/single_port_ram_arbiter.sv
// Round-robin arbiter sharing one write-first single-port RAM among NUM_REQ requesters.
// Define SPRA_LOCK_EN to add the lock port and the ARB/LOCKED ownership FSM.
module single_port_ram_arbiter
   import single_port_ram_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            we_in,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_in,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_in,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            rvalid,
   output logic [DATA_WIDTH-1:0]         rdata,
   output logic                          ram_we,
   output logic [ADDR_WIDTH-1:0]         ram_addr,
   output logic [DATA_WIDTH-1:0]         ram_data,
   input  logic [DATA_WIDTH-1:0]         ram_out,
`ifdef SPRA_LOCK_EN
   input  logic [NUM_REQ-1:0]            lock,
`endif
   output logic                          o_dbg_state
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // Handshake: req is a level held with stable we/addr/data until gnt; gnt[i] high in a
   // cycle means slot i's access is issued at the closing edge, and rvalid[i] with rdata
   // follows exactly two cycles later. No backpressure exists on the response side.
   logic                  r_ready;
   logic [PW-1:0]         r_ptr;
   logic [NUM_REQ-1:0]    r_v1;
   logic [NUM_REQ-1:0]    r_rvalid;
   logic [DATA_WIDTH-1:0] r_rdata;

   logic [NUM_REQ-1:0]    w_pick_gnt;
   logic [PW-1:0]         w_pick_idx;
   logic                  w_pick_any;
   logic [NUM_REQ-1:0]    w_gnt;
   logic [PW-1:0]         w_idx;
   logic                  w_any;

   rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
      .i_req (req),
      .i_ptr (r_ptr),
      .o_gnt (w_pick_gnt),
      .o_idx (w_pick_idx),
      .o_any (w_pick_any)
   );

`ifdef SPRA_LOCK_EN
   logic          r_state;
   logic [PW-1:0] r_owner;
   logic          w_hold;

   // Ownership lapses in the very cycle the owner drops lock, so that cycle re-arbitrates.
   assign w_hold = (r_state == ST_LOCKED) && lock[r_owner];

   always_comb begin
      w_gnt = '0;
      w_idx = w_pick_idx;
      w_any = 1'b0;
      if (r_ready) begin
         if (w_hold) begin
            w_idx          = r_owner;
            w_any          = req[r_owner];
            w_gnt[r_owner] = req[r_owner];
         end else begin
            w_gnt = w_pick_gnt;
            w_any = w_pick_any;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_ARB;
         r_owner <= '0;
      end else if (w_any && lock[w_idx]) begin
         r_state <= ST_LOCKED;
         r_owner <= w_idx;
      end else if (!w_hold) begin
         r_state <= ST_ARB;
      end
   end

   assign o_dbg_state = r_state;
`else
   always_comb begin
      w_gnt = r_ready ? w_pick_gnt : '0;
      w_idx = w_pick_idx;
      w_any = r_ready & w_pick_any;
   end

   assign o_dbg_state = ST_ARB;
`endif

   assign gnt      = w_gnt;
   assign ram_we   = w_any & we_in[w_idx];
   assign ram_addr = w_any ? addr_in[int'(w_idx)*ADDR_WIDTH +: ADDR_WIDTH]
                           : addr_in[ADDR_WIDTH-1:0];
   assign ram_data = w_any ? wdata_in[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH]
                           : wdata_in[DATA_WIDTH-1:0];

   // Two-stage valid: one stage for the RAM's output register, one for r_rdata.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ready  <= 1'b0;
         r_ptr    <= '0;
         r_v1     <= '0;
         r_rvalid <= '0;
         r_rdata  <= '0;
      end else begin
         r_ready  <= 1'b1;
         if (w_any) r_ptr <= PW'(wrap_inc(int'(w_idx), NUM_REQ));
         r_v1     <= w_gnt;
         r_rvalid <= r_v1;
         r_rdata  <= ram_out;
      end
   end

   assign rvalid = r_rvalid;
   assign rdata  = r_rdata;

endmodule
